// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - state encoding and shared widths for the ADC scan sequencer
package adc_seq_pkg;

    localparam int SETTLE_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_STORE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_START  = ST_START,
        S_WAIT   = ST_WAIT,
        S_STORE  = ST_STORE
    } seq_state_e;

endpackage

// File: rtl/adc_seq_chsel.sv
// rtl/adc_seq_chsel.sv - combinational finder of the next enabled channel at or above cur
module adc_seq_chsel #(
    parameter int NCH = 8,
    parameter int CHW = 3
) (
    input  logic [NCH-1:0] mask,
    input  logic [CHW-1:0] cur,
    input  logic           incl,
    output logic [CHW-1:0] nxt,
    output logic           found
);

    // Descending walk so the lowest qualifying bit is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                nxt   = CHW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - multi-channel SAR scan sequencer; ADC_SEQ_AVG_EN adds per-channel averaging
module adc_scan_sequencer #(
    parameter int SIZE     = 8,
    parameter int NCH      = 8,
    parameter int CHW      = 3,
`ifdef ADC_SEQ_AVG_EN
    parameter int AVG_LOG2 = 2,
`endif
    parameter int TMO      = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            trig,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [7:0]      settle,
    input  logic            clr,
    output logic            sar_start,
    input  logic            sar_done,
    input  logic [SIZE-1:0] sar_data,
    output logic [CHW-1:0]  mux_sel,
    output logic            sh_en,
    output logic [SIZE-1:0] dout,
    output logic [CHW-1:0]  dout_ch,
    output logic            dout_vld,
    output logic            eos,
    output logic            busy,
    output logic            ovr,
    output logic            err
);

    import adc_seq_pkg::*;

    localparam int TW = $clog2(TMO + 1);

    seq_state_e          state;
    logic [NCH-1:0]      mask_q;
    logic [CHW-1:0]      ch;
    logic [CHW-1:0]      first_ch;
    logic [SETTLE_W-1:0] scnt;
    logic [SETTLE_W-1:0] settle_last;
    logic [TW-1:0]       tmr;
    logic [CHW-1:0]      live_first;
    logic                live_any;
    logic [CHW-1:0]      nxt_ch;
    logic                nxt_found;
    logic [SIZE-1:0]     result;

    adc_seq_chsel #(.NCH(NCH), .CHW(CHW)) u_first (
        .mask  (ch_mask),
        .cur   ('0),
        .incl  (1'b1),
        .nxt   (live_first),
        .found (live_any)
    );

    adc_seq_chsel #(.NCH(NCH), .CHW(CHW)) u_next (
        .mask  (mask_q),
        .cur   (ch),
        .incl  (1'b0),
        .nxt   (nxt_ch),
        .found (nxt_found)
    );

    // A settle of 0 behaves as 1, so the last count index is settle-1 clamped at 0.
    assign settle_last = (settle == '0) ? '0 : settle - 1'b1;

`ifdef ADC_SEQ_AVG_EN
    localparam int ACC_W = SIZE + AVG_LOG2;

    logic [AVG_LOG2:0] avg_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic              avg_last;

    assign acc_sum  = acc + ACC_W'(sar_data);
    assign avg_last = (avg_cnt == (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1));
    assign result   = SIZE'(acc_sum >> AVG_LOG2);
`else
    assign result   = sar_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mask_q    <= '0;
            ch        <= '0;
            first_ch  <= '0;
            scnt      <= '0;
            tmr       <= '0;
            mux_sel   <= '0;
            sh_en     <= 1'b0;
            sar_start <= 1'b0;
            dout      <= '0;
            dout_ch   <= '0;
            dout_vld  <= 1'b0;
            eos       <= 1'b0;
            ovr       <= 1'b0;
            err       <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            acc       <= '0;
            avg_cnt   <= '0;
`endif
        end else begin
            sar_start <= 1'b0;
            dout_vld  <= 1'b0;
            eos       <= 1'b0;

            if (trig && (state != S_IDLE)) ovr <= 1'b1;
            else if (clr)                  ovr <= 1'b0;
            if (clr) err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trig && en && live_any) begin
                        mask_q   <= ch_mask;
                        ch       <= live_first;
                        first_ch <= live_first;
                        mux_sel  <= live_first;
                        sh_en    <= 1'b1;
                        scnt     <= '0;
                        busy     <= 1'b1;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
`ifdef ADC_SEQ_AVG_EN
                    acc     <= '0;
                    avg_cnt <= '0;
`endif
                    if (!en) begin
                        sh_en <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (scnt == settle_last) begin
                        sh_en     <= 1'b0;
                        sar_start <= 1'b1;
                        state     <= S_START;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_START: begin
                    tmr   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sar_done) begin
                        if (!en) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
`ifdef ADC_SEQ_AVG_EN
                        else if (!avg_last) begin
                            acc       <= acc_sum;
                            avg_cnt   <= avg_cnt + 1'b1;
                            sar_start <= 1'b1;
                            state     <= S_START;
                        end
`endif
                        else begin
                            dout     <= result;
                            dout_ch  <= ch;
                            dout_vld <= 1'b1;
                            eos      <= !nxt_found;
                            state    <= S_STORE;
                        end
                    end else if (tmr == TW'(TMO - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_STORE: begin
                    // Continuous restarts reuse the mask latched at the original trigger.
                    if (en && (nxt_found || cont)) begin
                        ch      <= nxt_found ? nxt_ch : first_ch;
                        mux_sel <= nxt_found ? nxt_ch : first_ch;
                        sh_en   <= 1'b1;
                        scnt    <= '0;
                        state   <= S_SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    sh_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - scoreboard bench for adc_scan_sequencer with a timed SAR model
module tb_adc_scan_sequencer;

    localparam int SIZE = 8;
    localparam int NCH  = 8;
    localparam int CHW  = 3;
    localparam int TMO  = 12;
`ifdef ADC_SEQ_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            trig = 1'b0;
    logic            cont = 1'b0;
    logic [NCH-1:0]  ch_mask = '0;
    logic [7:0]      settle = '0;
    logic            clr = 1'b0;
    logic            sar_done = 1'b0;
    logic [SIZE-1:0] sar_data = '0;
    logic            sar_start;
    logic [CHW-1:0]  mux_sel;
    logic            sh_en;
    logic [SIZE-1:0] dout;
    logic [CHW-1:0]  dout_ch;
    logic            dout_vld;
    logic            eos;
    logic            busy;
    logic            ovr;
    logic            err;

    adc_scan_sequencer #(.SIZE(SIZE), .NCH(NCH), .CHW(CHW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .cont(cont), .ch_mask(ch_mask),
        .settle(settle), .clr(clr), .sar_start(sar_start), .sar_done(sar_done),
        .sar_data(sar_data), .mux_sel(mux_sel), .sh_en(sh_en), .dout(dout),
        .dout_ch(dout_ch), .dout_vld(dout_vld), .eos(eos), .busy(busy), .ovr(ovr), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int data;
        int eos;
    } exp_t;

    exp_t            expq[$];
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              nvld = 0;
    int              sar_delay = 1;
    int              avg_idx = 0;
    bit              sar_hang = 1'b0;
    logic [SIZE-1:0] chdata[NCH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a channel's result is the truncated mean of the conversions the SAR returns.
    function automatic int exp_data(int c);
        int s = 0;
        for (int j = 0; j < NCONV; j++) s += int'(chdata[c]) + j;
        return s / NCONV;
    endfunction

    function automatic void push_scan(logic [NCH-1:0] m, int s, int d, int reps, int t0);
        int ns  = (s == 0) ? 1 : s;
        int len = ns + NCONV * (d + 1) + 1;
        int k   = 0;
        int top = 0;
        exp_t e;
        for (int c = 0; c < NCH; c++) if (m[c]) top = c;
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    k++;
                    e.cyc  = t0 + k * len;
                    e.ch   = c;
                    e.data = exp_data(c);
                    e.eos  = (c == top) ? 1 : 0;
                    expq.push_back(e);
                end
            end
        end
    endfunction

    // SAR macro: done (with data for the muxed channel) sar_delay cycles after each start.
    always begin : sar_model
        logic [CHW-1:0] sel;
        @(negedge clk);
        if (sar_start && !sar_hang) begin
            sel = mux_sel;
            repeat (sar_delay) @(posedge clk);
            #1;
            sar_done = 1'b1;
            sar_data = chdata[sel] + SIZE'(avg_idx);
            avg_idx  = (avg_idx + 1) % NCONV;
            @(posedge clk);
            #1;
            sar_done = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (dout_vld) begin
                nvld++;
                if (expq.size() == 0) begin
                    chk("spurious_vld", 32'(dout_vld), 0);
                end else begin
                    e = expq.pop_front();
                    chk("vld_cycle", cyc, e.cyc);
                    chk("dout_ch", 32'(dout_ch), e.ch);
                    chk("dout", 32'(dout), e.data);
                    chk("eos", 32'(eos), e.eos);
                end
            end else if (eos) begin
                chk("eos_without_vld", 32'(eos), 0);
            end
        end
    end

    task automatic fire(input logic [NCH-1:0] m, input int s, input int d, input int reps,
                        output int t0);
        @(posedge clk);
        #1;
        ch_mask   = m;
        settle    = 8'(s);
        sar_delay = d;
        avg_idx   = 0;
        trig      = 1'b1;
        t0        = cyc;
        push_scan(m, s, d, reps, t0);
        @(posedge clk);
        #1;
        trig = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || expq.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_idle"}, 32'(busy), 0);
        chk({name, "_drained"}, expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int p, n, nv0;
        for (int i = 0; i < NCH; i++) chdata[i] = SIZE'(i * 16);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mux", 32'(mux_sel), 0);
        chk("rst_sh_en", 32'(sh_en), 0);
        chk("rst_start", 32'(sar_start), 0);
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_ovr", 32'(ovr), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        en    = 1'b1;

        @(posedge clk);
        #1;
        ch_mask = '0;
        trig    = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        chk("mask0_ignored", 32'(busy), 0);

        fire(8'b0000_0101, 3, 10, 1, p);
        wait_idle("basic");

        fire(8'b0011_0010, 2, 5, 1, p);
        repeat (3) @(posedge clk);
        #1;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        chk("ovr_set", 32'(ovr), 1);
        wait_idle("ovr_scan");
        chk("ovr_sticky", 32'(ovr), 1);
        fire(8'h01, 4, 6, 1, p);
        trig = 1'b1;
        clr  = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        clr  = 1'b0;
        chk("ovr_set_beats_clr", 32'(ovr), 1);
        wait_idle("ovr_clr_scan");
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("ovr_cleared", 32'(ovr), 0);

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NCH; i++)
                chdata[i] = SIZE'($urandom_range(0, (1 << SIZE) - NCONV));
            fire(NCH'($urandom_range(1, (1 << NCH) - 1)), $urandom_range(0, 4),
                 $urandom_range(1, TMO), 1, p);
            ch_mask = NCH'($urandom);
            wait_idle("rand");
        end

        cont = 1'b1;
        nv0  = nvld;
        fire(8'h80, 1, 3, 3, p);
        n = 0;
        while (expq.size() > 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cont = 1'b0;
        wait_idle("cont");
        chk("cont_vld_count", nvld - nv0, 3);

        sar_hang = 1'b1;
        fire(8'h02, 2, 5, 0, p);
        while (cyc < p + 2 + 2 + TMO - 1) begin
            @(posedge clk);
            #1;
        end
        chk("tmo_err_early", 32'(err), 0);
        chk("tmo_busy_early", 32'(busy), 1);
        @(posedge clk);
        #1;
        chk("tmo_err", 32'(err), 1);
        chk("tmo_idle", 32'(busy), 0);
        sar_hang = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("err_cleared", 32'(err), 0);

        chdata[0] = 8'h5A;
        fire(8'h01, 0, 4, 1, p);
        chk("s0_sh_en", 32'(sh_en), 1);
        chk("s0_no_start", 32'(sar_start), 0);
        chk("s0_mux", 32'(mux_sel), 0);
        @(posedge clk);
        #1;
        chk("s0_sh_off", 32'(sh_en), 0);
        chk("s0_start", 32'(sar_start), 1);
        wait_idle("settle0");

        nv0 = nvld;
        fire(8'h0F, 2, 6, 0, p);
        n = 0;
        while (!sar_start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("endrop_start_seen", 32'(sar_start), 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_idle("endrop");
        chk("endrop_no_vld", nvld - nv0, 0);
        en = 1'b1;

`ifdef ADC_SEQ_AVG_EN
        chdata[1] = 8'd10;
        fire(8'h02, 1, 3, 1, p);
        wait_idle("avg");
`endif

        fire(8'hF0, 6, 5, 0, p);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sh_en", 32'(sh_en), 0);
        chk("arst_mux", 32'(mux_sel), 0);
        chk("arst_start", 32'(sar_start), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        fire(8'h11, 2, 5, 1, p);
        wait_idle("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
